// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one RS232 transmit serializer between two byte sources.
// Issues one tx_flag pulse per accepted byte, then blocks new grants for a full frame time.
module uart_tx_arbiter #(
    parameter int MAX_CNT    = 5208,
    parameter int FRAME_BITS = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    output logic       s1_ready,
    output logic [7:0] tx_data,
    output logic       tx_flag,
    output logic       busy,
    output logic       grant_id
);

    localparam int FRAME_CYCLES = FRAME_BITS * MAX_CNT;
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT
    } state_t;

    state_t             state;
    logic               last;
    logic [CNT_W-1:0]   cnt;

    // Handshake: a byte moves when sK_valid && sK_ready are both high at a
    // rising edge. Ready only rises in IDLE and for at most one source; when
    // both request, the one that did not win last time gets the slot.
    always_comb begin
        s0_ready = (state == S_IDLE) && s0_valid && (!s1_valid || last);
        s1_ready = (state == S_IDLE) && s1_valid && (!s0_valid || !last);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            tx_data  <= 8'h00;
            tx_flag  <= 1'b0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            last     <= 1'b1;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_flag <= 1'b0;
                    if (s0_ready) begin
                        tx_data  <= s0_data;
                        grant_id <= 1'b0;
                        last     <= 1'b0;
                        tx_flag  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end else if (s1_ready) begin
                        tx_data  <= s1_data;
                        grant_id <= 1'b1;
                        last     <= 1'b1;
                        tx_flag  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The serializer has no busy output, so pace a full frame here.
                    tx_flag <= 1'b0;
                    cnt     <= CNT_W'(FRAME_CYCLES - 1);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    tx_flag <= 1'b0;
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    tx_flag <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with MAX_CNT=4, FRAME_BITS=10 (40-cycle frames).
// A negedge monitor checks every tx_flag byte against an expected queue.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rstn;
    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_ready;
    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_ready;
    logic [7:0] tx_data;
    logic       tx_flag;
    logic       busy;
    logic       grant_id;

    int total = 0;
    int bad   = 0;
    int flag_cnt = 0;
    int cycle = 0;
    int last_flag_cycle = -1;
    logic [7:0] exp_q[$];

    uart_tx_arbiter #(.MAX_CNT(4), .FRAME_BITS(10)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_ready (s1_ready),
        .tx_data  (tx_data),
        .tx_flag  (tx_flag),
        .busy     (busy),
        .grant_id (grant_id)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // scoreboard / protocol monitor
    always @(negedge clk) begin
        cycle++;
        if (!rstn) begin
            last_flag_cycle = -1;
        end else begin
            total++;
            assert (!(s0_ready && s1_ready))
            else begin
                bad++;
                $error("FAIL both_ready observed=%0b%0b expected=not_11", s0_ready, s1_ready);
            end
            if (tx_flag) begin
                flag_cnt++;
                if (last_flag_cycle >= 0) begin
                    total++;
                    assert (cycle - last_flag_cycle >= 42)
                    else begin
                        bad++;
                        $error("FAIL flag_spacing observed=%0d expected>=42", cycle - last_flag_cycle);
                    end
                end
                last_flag_cycle = cycle;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $error("FAIL sb_unexpected observed=%0h expected=none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    assert (tx_data === e)
                    else begin
                        bad++;
                        $error("FAIL sb_byte observed=%0h expected=%0h", tx_data, e);
                    end
                end
            end
        end
    end

    initial begin
        int f0;
        rstn = 1'b0;
        s0_valid = 1'b0;
        s0_data = 8'h00;
        s1_valid = 1'b0;
        s1_data = 8'h00;

        // 1. reset values and idle quiet period
        step_n(3);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_tx_flag", 32'(tx_flag), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_s0_ready", 32'(s0_ready), 32'h0);
        chk("rst_s1_ready", 32'(s1_ready), 32'h0);
        rstn = 1'b1;
        f0 = flag_cnt;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_flag", 32'(tx_flag), 32'h0);
        end
        chk("idle_no_flags", 32'(flag_cnt - f0), 32'd0);

        // 2. single byte from s0
        s0_valid = 1'b1;
        s0_data = 8'hA5;
        exp_q.push_back(8'hA5);
        #1;
        chk("t2_s0_ready", 32'(s0_ready), 32'h1);
        step();
        s0_valid = 1'b0;
        chk("t2_flag", 32'(tx_flag), 32'h1);
        chk("t2_data", 32'(tx_data), 32'hA5);
        chk("t2_busy_load", 32'(busy), 32'h1);
        chk("t2_grant", 32'(grant_id), 32'h0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("t2_wait_busy", 32'(busy), 32'h1);
            chk("t2_wait_flag", 32'(tx_flag), 32'h0);
            chk("t2_wait_ready", 32'(s0_ready), 32'h0);
        end
        step();
        chk("t2_idle_busy", 32'(busy), 32'h0);
        chk("t2_hold_data", 32'(tx_data), 32'hA5);
        s0_valid = 1'b1;
        #1;
        chk("t2_ready_again", 32'(s0_ready), 32'h1);
        s0_valid = 1'b0;

        // 3. contention from reset: s0 wins first, then alternate
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        s0_valid = 1'b1;
        s0_data = 8'h11;
        s1_valid = 1'b1;
        s1_data = 8'h22;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        #1;
        chk("t3_first_s0_ready", 32'(s0_ready), 32'h1);
        chk("t3_first_s1_ready", 32'(s1_ready), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_flag", 32'(tx_flag), 32'h1);
            chk("t3_data", 32'(tx_data), (k % 2 == 0) ? 32'h11 : 32'h22);
            chk("t3_grant", 32'(grant_id), 32'(k % 2));
            step_n(41);
            chk("t3_next_s0_ready", 32'(s0_ready), (k % 2 == 1) ? 32'h1 : 32'h0);
            chk("t3_next_s1_ready", 32'(s1_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4. late arrival of s1 during an s0 frame
        s0_valid = 1'b1;
        s0_data = 8'h5A;
        exp_q.push_back(8'h5A);
        step();
        s0_valid = 1'b0;
        chk("t4_s0_flag", 32'(tx_flag), 32'h1);
        step_n(5);
        s1_valid = 1'b1;
        s1_data = 8'h3C;
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 36; i++) begin
            #1;
            chk("t4_s1_ready_wait", 32'(s1_ready), 32'h0);
            step();
        end
        chk("t4_busy_end", 32'(busy), 32'h0);
        chk("t4_s1_ready_idle", 32'(s1_ready), 32'h1);
        step();
        s1_valid = 1'b0;
        chk("t4_flag", 32'(tx_flag), 32'h1);
        chk("t4_data", 32'(tx_data), 32'h3C);
        chk("t4_grant", 32'(grant_id), 32'h1);
        step_n(41);
        chk("t4_sent_once", 32'(exp_q.size()), 32'd0);

        // 5. withdrawn s0 request during an s1 frame
        s1_valid = 1'b1;
        s1_data = 8'h44;
        exp_q.push_back(8'h44);
        f0 = flag_cnt;
        step();
        s1_valid = 1'b0;
        chk("t5_grant", 32'(grant_id), 32'h1);
        step_n(10);
        s0_valid = 1'b1;
        s0_data = 8'h99;
        step();
        s0_valid = 1'b0;
        step_n(30);
        chk("t5_busy_end", 32'(busy), 32'h0);
        chk("t5_one_flag", 32'(flag_cnt - f0), 32'd1);
        s0_valid = 1'b1;
        s0_data = 8'h66;
        s1_valid = 1'b1;
        s1_data = 8'h55;
        exp_q.push_back(8'h66);
        #1;
        chk("t5_rr_s0_ready", 32'(s0_ready), 32'h1);
        chk("t5_rr_s1_ready", 32'(s1_ready), 32'h0);

        // 6. mid-frame reset with s1 still pending
        step();
        s0_valid = 1'b0;
        chk("t6_flag", 32'(tx_flag), 32'h1);
        chk("t6_data", 32'(tx_data), 32'h66);
        chk("t6_grant", 32'(grant_id), 32'h0);
        step_n(8);
        rstn = 1'b0;
        step();
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_flag", 32'(tx_flag), 32'h0);
        chk("t6_rst_data", 32'(tx_data), 32'h00);
        chk("t6_rst_grant", 32'(grant_id), 32'h0);
        rstn = 1'b1;
        exp_q.push_back(8'h55);
        #1;
        chk("t6_s1_ready", 32'(s1_ready), 32'h1);
        step();
        s1_valid = 1'b0;
        chk("t6_s1_flag", 32'(tx_flag), 32'h1);
        chk("t6_s1_data", 32'(tx_data), 32'h55);
        chk("t6_s1_grant", 32'(grant_id), 32'h1);
        step_n(41);
        chk("t6_busy_end", 32'(busy), 32'h0);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single RS232 transmit serializer (`tx`, driven by `data`/`flag`) between two byte sources, e.g. the `rx` echo path and a local status/message generator. Uses round-robin arbitration with a valid/ready handshake per source. It issues one `flag` pulse per byte, then holds off further grants for the full serial frame time. The serializer has no busy output, so the block owns frame pacing.

## Interface
Parameters:
- `MAX_CNT`, 5208: clock cycles per bit; must equal the serializer's `MAX_CNT`.
- `FRAME_BITS`, 10: bits per frame (start + 8 data + stop).
- Derived: `FRAME_CYCLES` = `FRAME_BITS*MAX_CNT`. Counter width is `$clog2(FRAME_CYCLES+1)` (16 bits at defaults).

Ports:
- `clk` input 1: single clock.
- `rstn` input 1: reset; synchronous and active-low.
- `s0_valid` input 1: source 0 has a byte.
- `s0_data` input 8: source 0 byte.
- `s0_ready` output 1: source 0 byte accepted this cycle when `s0_valid` is also high.
- `s1_valid`, `s1_data`, `s1_ready`: same as above, for source 1.
- `tx_data` output 8: to serializer `data`.
- `tx_flag` output 1: to serializer `flag`; one-cycle pulse per byte.
- `busy` output 1: a frame is being loaded or transmitted.
- `grant_id` output 1: source of the most recently accepted byte.

## Operation
States:
- IDLE: `busy`=0.
  - If any `sK_valid` is high, assert `sK_ready` for exactly one source, chosen by round-robin.
  - If only one source is valid, it wins.
  - If both are valid, the source not equal to `last` wins.
  - On accept: latch `sK_data` into `tx_data`, set `grant_id`=K, set `last`=K, go to LOAD.
- LOAD (1 cycle):
  - `tx_flag`=1, `busy`=1, `tx_data` stable.
  - Load counter = `FRAME_CYCLES`-1, go to WAIT.
- WAIT:
  - `busy`=1, `tx_flag`=0; counter decrements each cycle.
  - At counter = 0, go to IDLE.
- `sK_ready` is combinational from state, `last` and both valids. It is high only in IDLE and never high for both sources in the same cycle.
- Source rules:
  - A source must hold `valid` and `data` stable until `ready`.
  - The arbiter never drops or duplicates an accepted byte.
  - Deasserting `valid` before `ready` withdraws the request with no side effects.
- `tx_data` and `grant_id` hold their value between frames.
- Reset values: state IDLE, `tx_data`=8'h00, `tx_flag`=0, `busy`=0, `grant_id`=0, `last`=1 (source 0 wins the first contention), counter 0.

## Timing
- Accept edge T: IDLE, valid & ready sampled high.
- T+1: LOAD; `tx_flag`=1 and `tx_data` = accepted byte in the same cycle.
- T+2 … T+1+`FRAME_CYCLES`: WAIT (`FRAME_CYCLES` cycles).
- T+2+`FRAME_CYCLES`: IDLE; `ready` may assert, so the next accept can occur in that cycle.
- Minimum accept spacing: `FRAME_CYCLES`+2 cycles. Consecutive `tx_flag` pulses are likewise ≥ `FRAME_CYCLES`+2 apart.
- `busy` is high from T+1 through the last WAIT cycle inclusive.
- Reset asserted mid-LOAD or mid-WAIT: at the next edge, all outputs take reset values and state is IDLE. A partially paced frame is abandoned; the serializer is reset by the same `rstn`.
- Valid arriving during LOAD/WAIT: `ready` stays low and the request waits; no accept, no error.
- A source staying valid continuously while the other is idle: it is granted every frame slot back-to-back.

## Test plan
Parameters for all scenarios: `MAX_CNT`=4, `FRAME_BITS`=10, so `FRAME_CYCLES`=40.

1. Reset release: every output reads its reset value; with no valids for 50 cycles, `tx_flag` never pulses and `busy`=0.
2. Single byte: `s0_valid`=1, `s0_data`=8'hA5 at accept edge T.
   - `s0_ready`=1 at T; `tx_flag`=1 with `tx_data`=8'hA5 at T+1 only.
   - `busy`=1 for T+1…T+41; `s0_ready` can next assert at T+42; `grant_id`=0.
3. Contention: both valid from reset, `s0`=8'h11, `s1`=8'h22, both held continuously.
   - Accept order: s0, s1, s0, s1.
   - `tx_flag` pulses 42 cycles apart with `tx_data` 11, 22, 11, 22; `grant_id` toggles.
   - Never both `ready` high in one cycle.
4. Late arrival: `s1` asserts valid with 8'h3C during WAIT of an `s0` frame.
   - `s1_ready` stays 0 until IDLE, then `s1` is accepted at the first IDLE cycle; the byte is sent exactly once.
5. Withdrawn request: `s0_valid` pulses 1 cycle during WAIT, then drops. No accept, no extra `tx_flag`, and the round-robin pointer is unchanged.
6. Mid-frame reset: `rstn`=0 for 1 cycle at T+10 after an accept.
   - Next edge: `busy`=0, `tx_flag`=0, `tx_data`=8'h00, `grant_id`=0.
   - A pending `s1` request is then granted at the first IDLE cycle.
